// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared RV32M funct3 codes, FSM encoding and width helper for muldiv_unit
package muldiv_pkg;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction
endpackage

// File: rtl/muldiv_unit_cond_neg.sv
// cond_neg: combinational conditional two's-complement negate of an N-bit value
module cond_neg #(
  parameter int N = 32
) (
  input  logic [N-1:0] i_val,
  input  logic         i_neg,
  output logic [N-1:0] o_val
);
  assign o_val = i_neg ? (~i_val + N'(1)) : i_val;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply (shift-add) / divide (restoring) on operand magnitudes.
// MULDIV_EARLY_OUT_EN: when defined, div-by-zero, signed overflow and zero operands skip CALC.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int B = 32,
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         start,
  input  logic [2:0]   funct3,
  input  logic [B-1:0] op_a,
  input  logic [B-1:0] op_b,
  input  logic [W-1:0] rd_in,
  output logic         busy,
  output logic         done,
  output logic         wr_en,
  output logic [W-1:0] w_addr,
  output logic [B-1:0] result
);
  localparam int CW = clog2(B);
  state_t r_state, w_nstate;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_f3;
  logic [W-1:0]  r_addr;
  logic [B-1:0]  r_a, r_b, r_hi, r_lo, r_res;
  logic          r_sa, r_sb, r_dz, r_ovf, r_zero;
  logic [B-1:0]  w_abs_a, w_abs_b, w_sub, w_nhi, w_nlo, w_sel, w_spec;
  logic [B:0]    w_madd, w_sh;
  logic [2*B-1:0] w_raw, w_fix;
  logic w_a_sgn, w_b_sgn, w_sa, w_sb, w_dz, w_ovf, w_zero, w_early;
  logic w_accept, w_last, w_ge, w_mul, w_rem, w_neg, w_special;
  assign w_a_sgn  = !(funct3 inside {F3_MULHU, F3_DIVU, F3_REMU});
  assign w_b_sgn  = w_a_sgn && funct3 != F3_MULHSU;
  assign w_sa     = w_a_sgn & op_a[B-1];
  assign w_sb     = w_b_sgn & op_b[B-1];
  assign w_dz     = funct3[2] && op_b == '0;
  assign w_ovf    = funct3[2] && !funct3[0] && op_a == {1'b1, {(B-1){1'b0}}} && op_b == '1;
  assign w_zero   = op_a == '0 || op_b == '0;
`ifdef MULDIV_EARLY_OUT_EN
  assign w_early  = w_dz | w_ovf | w_zero;
`else
  assign w_early  = 1'b0;
`endif
  cond_neg #(.N(B)) u_abs_a (.i_val(op_a), .i_neg(w_sa), .o_val(w_abs_a));
  cond_neg #(.N(B)) u_abs_b (.i_val(op_b), .i_neg(w_sb), .o_val(w_abs_b));
  assign w_accept = r_state == S_IDLE && start;
  assign w_last   = r_state == S_CALC && r_cnt == CW'(B-1);
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE:  if (start) w_nstate = w_early ? S_DONE : S_CALC;
      S_CALC:  if (w_last) w_nstate = S_DONE;
      default: w_nstate = S_IDLE;
    endcase
  end
  // One datapath step: shift-add for multiply, shift-compare-subtract for divide.
  assign w_mul  = !r_f3[2];
  assign w_rem  = r_f3[2] & r_f3[1];
  assign w_madd = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_sh   = {r_hi, r_lo[B-1]};
  assign w_ge   = w_sh >= {1'b0, r_b};
  assign w_sub  = w_sh[B-1:0] - r_b;
  assign w_nhi  = w_mul ? w_madd[B:1] : (w_ge ? w_sub : w_sh[B-1:0]);
  assign w_nlo  = w_mul ? {w_madd[0], r_lo[B-1:1]} : {r_lo[B-2:0], w_ge};
  // Full-width negate so MULH* see the high half of the sign-corrected product.
  assign w_raw  = w_mul ? {w_nhi, w_nlo} : {{B{1'b0}}, r_f3[1] ? w_nhi : w_nlo};
  assign w_neg  = (w_mul || !r_f3[1]) ? (r_sa ^ r_sb) : r_sa;
  cond_neg #(.N(2*B)) u_fix (.i_val(w_raw), .i_neg(w_neg), .o_val(w_fix));
  assign w_sel  = (w_mul && r_f3 != F3_MUL) ? w_fix[2*B-1:B] : w_fix[B-1:0];
  assign w_special = r_dz | r_ovf | r_zero;
  assign w_spec = r_dz ? (w_rem ? r_a : '1) : r_ovf ? (w_rem ? '0 : r_a) : '0;
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_res   <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_dz    <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      if (w_accept) begin
        r_cnt  <= '0;
        r_f3   <= funct3;
        r_addr <= rd_in;
        r_a    <= op_a;
        r_b    <= w_abs_b;
        r_hi   <= '0;
        r_lo   <= w_abs_a;
        r_sa   <= w_sa;
        r_sb   <= w_sb;
        r_dz   <= w_dz;
        r_ovf  <= w_ovf;
        r_zero <= w_zero;
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt + CW'(1);
        r_hi  <= w_nhi;
        r_lo  <= w_nlo;
        if (w_last) r_res <= w_sel;
      end
    end
  end
  assign busy   = r_state != S_IDLE;
  assign done   = r_state == S_DONE;
  assign wr_en  = done;
  assign w_addr = r_addr;
  assign result = w_special ? w_spec : r_res;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (B=32, W=5)
module tb_muldiv_unit;
  import muldiv_pkg::*;
  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done, wr_en;
  logic [4:0]  w_addr;
  logic [31:0] result;
  int n_cmp = 0, n_bad = 0;
  muldiv_unit #(.B(32), .W(5)) dut (
    .clk(clk), .n_reset(n_reset), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .busy(busy), .done(done),
    .wr_en(wr_en), .w_addr(w_addr), .result(result)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic int exp_lat(input logic special);
`ifdef MULDIV_EARLY_OUT_EN
    return special ? 1 : 33;
`else
    return special ? 33 : 33;
`endif
  endfunction
  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input logic special);
    int lat;
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op_a = ~a; op_b = ~b; rd_in = ~rd;
    lat = 1;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat(special)));
    check({tag, "_res"}, result, exp);
    check({tag, "_addr"}, 32'(w_addr), 32'(rd));
    check({tag, "_wren"}, 32'(wr_en), 32'd1);
    @(negedge clk);
    check({tag, "_pulse"}, {30'd0, done, busy}, 32'd0);
    check({tag, "_hold"}, result, exp);
  endtask
  initial begin
    int lat, extra;
    logic busy_ok;
    repeat (2) @(negedge clk);
    check("rst_outs", {29'd0, busy, done, wr_en}, 32'd0);
    check("rst_addr", 32'(w_addr), 32'd0);
    check("rst_res", result, 32'd0);
    n_reset = 1'b1;
    do_op("mul",     F3_MUL,    32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, 1'b0);
    do_op("mulhu",   F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE, 1'b0);
    do_op("mulh",    F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'h00000000, 1'b0);
    do_op("mulhsu",  F3_MULHSU, 32'hFFFFFFFF, 32'h00000002, 5'd6,  32'hFFFFFFFF, 1'b0);
    do_op("div",     F3_DIV,    32'hFFFFFFF9, 32'h00000002, 5'd7,  32'hFFFFFFFD, 1'b0);
    do_op("rem",     F3_REM,    32'hFFFFFFF9, 32'h00000002, 5'd8,  32'hFFFFFFFF, 1'b0);
    do_op("divu",    F3_DIVU,   32'h80000000, 32'h00000002, 5'd10, 32'h40000000, 1'b0);
    do_op("divu_z",  F3_DIVU,   32'd5,        32'd0,        5'd11, 32'hFFFFFFFF, 1'b1);
    do_op("remu_z",  F3_REMU,   32'd5,        32'd0,        5'd12, 32'd5,        1'b1);
    do_op("div_ovf", F3_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 1'b1);
    do_op("rem_ovf", F3_REM,    32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h00000000, 1'b1);
    do_op("div_z",   F3_DIV,    32'hFFFFFFF9, 32'd0,        5'd15, 32'hFFFFFFFF, 1'b1);
    // start held high across a whole op, DONE and the return to IDLE
    @(negedge clk);
    funct3 = F3_MULHU; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF; rd_in = 5'd9; start = 1'b1;
    @(negedge clk);
    lat = 1;
    busy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check("held_lat", 32'(lat), 32'd33);
    check("held_busy", 32'(busy_ok & busy), 32'd1);
    check("held_res", result, 32'hFFFFFFFE);
    @(negedge clk);
    check("held_idle", {30'd0, done, busy}, 32'd0);
    @(negedge clk);
    check("held_reaccept", 32'(busy), 32'd1);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("held_lat2", 32'(lat), 32'd33);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("held_single", 32'(extra), 32'd0);
    // reset in the middle of CALC
    @(negedge clk);
    funct3 = F3_DIVU; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd17; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    n_reset = 1'b0;
    @(negedge clk);
    check("mid_rst_outs", {29'd0, busy, done, wr_en}, 32'd0);
    check("mid_rst_res", result, 32'd0);
    check("mid_rst_addr", 32'(w_addr), 32'd0);
    n_reset = 1'b1;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || wr_en || busy) extra++;
    end
    check("mid_no_done", 32'(extra), 32'd0);
    do_op("mul_post", F3_MUL, 32'd3, 32'd4, 5'd21, 32'd12, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
